// File: rtl/det_pkg.sv
// det_pkg: shared types and constants for the sequential determinant unit.
//   det_state_e : controller states (IDLE, CALC, DONE)
//   mac_op_e    : operation applied by det_mac in the current cycle
//   MODE_2X2/3X3: values of the mode input
//   STEPS_*     : multiply steps per matrix size
//   acc_w()     : full-precision accumulator width for a given element width
package det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } det_state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_CLR,
        OP_MIN_LD,
        OP_MIN_SUB,
        OP_ACC_ADD,
        OP_ACC_SUB
    } mac_op_e;

    localparam logic MODE_2X2 = 1'b0;
    localparam logic MODE_3X3 = 1'b1;

    localparam int unsigned STEPS_2X2 = 2;
    localparam int unsigned STEPS_3X3 = 9;

    // e_k * minor needs 3*DATA_W+1 bits; two more cover the three-term sum.
    function automatic int unsigned acc_w(input int unsigned data_w);
        return 3 * data_w + 3;
    endfunction

endpackage

// File: rtl/det_mac.sv
// det_mac: single shared signed multiplier with minor and accumulator
// registers.
//   clk, rst      : clock, synchronous active-high reset
//   op_i          : operation for this cycle (see mac_op_e)
//   mul_a_i       : multiplier operand A (matrix element)
//   mul_b_i       : multiplier operand B when b_minor_i = 0 (matrix element)
//   b_minor_i     : 1 selects the minor register as operand B
//   acc_d_o       : accumulator value after this cycle's operation
module det_mac
    import det_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = acc_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  mac_op_e           op_i,
    input  logic [DATA_W-1:0] mul_a_i,
    input  logic [DATA_W-1:0] mul_b_i,
    input  logic              b_minor_i,
    output logic [ACC_W-1:0]  acc_d_o
);

    localparam int unsigned MIN_W  = 2 * DATA_W + 1;
    localparam int unsigned PROD_W = 3 * DATA_W + 1;

    logic signed [MIN_W-1:0]  minor_q, minor_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]  prod_acc;

    always_comb begin
        a_ext = {{(PROD_W-DATA_W){mul_a_i[DATA_W-1]}}, mul_a_i};
        if (b_minor_i) begin
            b_ext = {{(PROD_W-MIN_W){minor_q[MIN_W-1]}}, minor_q};
        end else begin
            b_ext = {{(PROD_W-DATA_W){mul_b_i[DATA_W-1]}}, mul_b_i};
        end
        // Both operands are sign-extended to the product width, so the
        // truncated product is exact.
        prod     = a_ext * b_ext;
        prod_acc = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

        minor_d = minor_q;
        acc_d   = acc_q;
        case (op_i)
            OP_CLR: begin
                minor_d = '0;
                acc_d   = '0;
            end
            OP_MIN_LD:  minor_d = prod[MIN_W-1:0];
            OP_MIN_SUB: minor_d = minor_q - prod[MIN_W-1:0];
            OP_ACC_ADD: acc_d   = acc_q + prod_acc;
            OP_ACC_SUB: acc_d   = acc_q - prod_acc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            minor_q <= '0;
            acc_q   <= '0;
        end else begin
            minor_q <= minor_d;
            acc_q   <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/det_seq.sv
// det_seq: sequential signed determinant of a 2x2 or 3x3 matrix with a
// valid/ready handshake on both sides and one shared multiplier.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   mode                 : 0 = 2x2, 1 = 3x3
//   l1, l2, l3           : rows packed {e0,e1,e2}, e0 in the MSBs; 2x2 uses
//                          the low 2*DATA_W bits of l1/l2 as {e0,e1}
//   out_valid / out_ready: result handshake
//   det                  : DATA_W-bit narrowed determinant
//   det_full             : exact ACC_W-bit signed determinant
//   ovf                  : det_full outside the signed DATA_W range
// Build option: define DET_SAT_EN to saturate det on overflow; otherwise
// det is the low DATA_W bits of det_full.
module det_seq
    import det_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = acc_w(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [3*DATA_W-1:0] l1,
    input  logic [3*DATA_W-1:0] l2,
    input  logic [3*DATA_W-1:0] l3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   det,
    output logic [ACC_W-1:0]    det_full,
    output logic                ovf
);

    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] NEG_LIM = ~POS_LIM;

    det_state_e            state_q, state_d;
    logic [3:0]            step_q, step_d;
    logic                  mode_q;
    logic [3*DATA_W-1:0]   l1_q, l2_q, l3_q;
    logic [DATA_W-1:0]     det_q, det_d;
    logic [ACC_W-1:0]      det_full_q;
    logic                  ovf_q, ovf_d;

    logic                  load_ops;
    logic                  last_step;
    logic [3:0]            last_idx;
    mac_op_e               op;
    logic [DATA_W-1:0]     mul_a, mul_b;
    logic                  b_minor;
    logic [ACC_W-1:0]      acc_next;

    function automatic logic [DATA_W-1:0] el(input logic [3*DATA_W-1:0] row,
                                             input int unsigned idx);
        return row[(2 - idx) * DATA_W +: DATA_W];
    endfunction

    det_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .op_i      (op),
        .mul_a_i   (mul_a),
        .mul_b_i   (mul_b),
        .b_minor_i (b_minor),
        .acc_d_o   (acc_next)
    );

    assign last_idx = (mode_q == MODE_3X3) ? 4'(STEPS_3X3 - 1) : 4'(STEPS_2X2 - 1);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        load_ops  = 1'b0;
        last_step = 1'b0;
        op        = OP_NOP;
        mul_a     = '0;
        mul_b     = '0;
        b_minor   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_ops = 1'b1;
                    op       = OP_CLR;
                    step_d   = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                step_d = step_q + 4'd1;
                // 2x2 elements sit at row indices 1 and 2, which keeps one
                // extraction scheme for both modes.
                if (mode_q == MODE_2X2) begin
                    case (step_q)
                        4'd0: begin
                            op = OP_ACC_ADD; mul_a = el(l1_q, 1); mul_b = el(l2_q, 2);
                        end
                        default: begin
                            op = OP_ACC_SUB; mul_a = el(l1_q, 2); mul_b = el(l2_q, 1);
                        end
                    endcase
                end else begin
                    // Rows [a b c]/[d e f]/[g h i]: three minors along row 1.
                    case (step_q)
                        4'd0: begin op = OP_MIN_LD;  mul_a = el(l2_q, 1); mul_b = el(l3_q, 2); end
                        4'd1: begin op = OP_MIN_SUB; mul_a = el(l2_q, 2); mul_b = el(l3_q, 1); end
                        4'd2: begin op = OP_ACC_ADD; mul_a = el(l1_q, 0); b_minor = 1'b1; end
                        4'd3: begin op = OP_MIN_LD;  mul_a = el(l2_q, 0); mul_b = el(l3_q, 2); end
                        4'd4: begin op = OP_MIN_SUB; mul_a = el(l2_q, 2); mul_b = el(l3_q, 0); end
                        4'd5: begin op = OP_ACC_SUB; mul_a = el(l1_q, 1); b_minor = 1'b1; end
                        4'd6: begin op = OP_MIN_LD;  mul_a = el(l2_q, 0); mul_b = el(l3_q, 1); end
                        4'd7: begin op = OP_MIN_SUB; mul_a = el(l2_q, 1); mul_b = el(l3_q, 0); end
                        default: begin op = OP_ACC_ADD; mul_a = el(l1_q, 2); b_minor = 1'b1; end
                    endcase
                end
                if (step_q == last_idx) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Narrowing is computed from the accumulator's next value so the
    // registered result appears together with out_valid.
    always_comb begin
        ovf_d = ($signed(acc_next) > POS_LIM) || ($signed(acc_next) < NEG_LIM);
`ifdef DET_SAT_EN
        if (ovf_d) begin
            det_d = acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            det_d = acc_next[DATA_W-1:0];
        end
`else
        det_d = acc_next[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            mode_q     <= MODE_2X2;
            l1_q       <= '0;
            l2_q       <= '0;
            l3_q       <= '0;
            det_q      <= '0;
            det_full_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (load_ops) begin
                mode_q <= mode;
                l1_q   <= l1;
                l2_q   <= l2;
                l3_q   <= l3;
            end
            if (last_step) begin
                det_q      <= det_d;
                det_full_q <= acc_next;
                ovf_q      <= ovf_d;
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign det       = det_q;
    assign det_full  = det_full_q;
    assign ovf       = ovf_q;

endmodule
